execute_writeback_stage: RTL and testbench
==========================================

Name:
execute_writeback_stage

Overview:
- Producer end of the execute forwarding interface.
- Registers execute results into a current writeback stage that drives the register-file write port and the iWB_* forwarding inputs.
- Keeps a one-deep history of the last retired write (the iPREV_WB_* forwarding inputs), which covers the register-file write latency.
- Sits between the execute ALU/result mux and the register file.

Parameters:
- None. Widths are fixed by the ISA: 32-bit data, 5-bit register pointer.

Ports:
iCLOCK  in  1  core clock; all state changes on the rising edge
iRESET  in  1  asynchronous active-high reset
iFLUSH  in  1  pipeline flush (branch/exception); drops the unretired entry
iEXE_VALID  in  1  execute presents a result this cycle
oEXE_LOCK  out  1  stage cannot accept; execute must hold its result
iEXE_GR_VALID  in  1  result writes a GR or sysreg
iEXE_GR_DATA  in  32  GR/sysreg write data
iEXE_GR_DEST  in  5  destination pointer
iEXE_GR_DEST_SYSREG  in  1  destination is a system register
iEXE_SPR_VALID  in  1  result also updates the stack pointer
iEXE_SPR_DATA  in  32  new SPR value
iRF_BUSY  in  1  register file write port unavailable this cycle
oRF_WE  out  1  current entry is written to the register file this cycle
oWB_GR_VALID  out  1  current stage: GR write pending
oWB_GR_DATA  out  32  current stage: data
oWB_GR_DEST  out  5  current stage: pointer
oWB_GR_DEST_SYSREG  out  1  current stage: sysreg flag
oWB_SPR_VALID  out  1  current stage: SPR write pending
oWB_SPR_DATA  out  32  current stage: SPR data
oPREV_WB_GR_VALID  out  1  history: GR write retired last cycle
oPREV_WB_GR_DATA  out  32  history: data
oPREV_WB_GR_DEST  out  5  history: pointer
oPREV_WB_GR_DEST_SYSREG  out  1  history: sysreg flag
oPREV_WB_SPR_VALID  out  1  history: SPR write retired last cycle
oPREV_WB_SPR_DATA  out  32  history: SPR data

Behaviour:
- **State:** one current entry (internal valid bit `cur_v` plus fields) and one history entry.
- **Reset:** iRESET asserted clears every output register to 0 asynchronously. oEXE_LOCK and oRF_WE read 0 after reset.
- **Retire:** `retire = cur_v && !iRF_BUSY`. oRF_WE = retire, combinational.
- **Lock:** oEXE_LOCK = cur_v && iRF_BUSY, combinational. This is the only back-pressure.
- **Accept:** `accept = iEXE_VALID && !oEXE_LOCK && !iFLUSH`. It loads the current entry from iEXE_*, with `cur_v` set to 1.
  - An accept with iEXE_GR_VALID=0 and iEXE_SPR_VALID=0 still occupies the stage.
  - Latency: one cycle from accept to oWB_* visible.
- **Hold:** if `cur_v` and iRF_BUSY, the current entry holds and the history entry is invalidated on the next edge.
- **Drain:** a retire with no accept clears `cur_v` and all oWB_*_VALID bits on the next edge.
- **History, on every edge:**
  - If retire, history <- current entry, so PREV valid bits equal the current valid bits.
  - Otherwise, oPREV_WB_GR_VALID and oPREV_WB_SPR_VALID <- 0 and the history data holds.
  - A history entry is valid for exactly one cycle.
- **Flush:**
  - The unretired current entry is dropped: `cur_v` and oWB_*_VALID <- 0, and no accept happens.
  - If the current entry retires in the flush cycle, the write is committed and it still moves to history. Retire wins over flush for that entry.
- **Back-to-back:** retire and accept in the same cycle gives full throughput of one result per cycle.
- **Data hygiene:** when `cur_v` is 0, oWB data fields hold their last value but all valid bits are 0.

Optional Feature:
- **EXECUTE_WB_FRCR_EN defined:**
  - Adds iEXE_FRCR_VALID (1 bit) and iEXE_FRCR_DATA (64 bits).
  - Adds oWB_FRCR_VALID/oWB_FRCR_DATA and oPREV_WB_FRCR_VALID/oPREV_WB_FRCR_DATA.
  - These are staged exactly like the SPR fields: same accept/hold/retire/flush rules, 64-bit data, reset 0.
- **Undefined:** the ports are absent and no FRCR registers are built.

Test Plan:
- **Reset mid-operation:** assert iRESET with `cur_v`=1 and iRF_BUSY=1 -> all outputs 0 immediately; oEXE_LOCK=0.
- **Single write:** accept GR_DEST=5, DATA=0x1234_5678, iRF_BUSY=0 -> next cycle oWB_GR_VALID=1 and oRF_WE=1; cycle after, oPREV_WB_GR_VALID=1 with DEST=5 and DATA=0x12345678; one cycle later, oPREV_WB_GR_VALID=0.
- **Stall:** current valid, iRF_BUSY=1 for 3 cycles while iEXE_VALID=1 -> oEXE_LOCK=1 for 3 cycles; oWB_* stable; oPREV valid=0; the held result is accepted the cycle iRF_BUSY drops.
- **Streaming:** 4 back-to-back accepts (DEST 1..4, SPR_VALID on the 2nd with 0x0000_FF00) -> oRF_WE high 4 consecutive cycles; PREV outputs follow WB by exactly 1 cycle; the SPR valid pulse appears once on each bus.
- **Flush with hold:** flush with `cur_v`=1 and iRF_BUSY=1 -> oWB_GR_VALID=0 next cycle; no write; PREV valid=0. Flush with iRF_BUSY=0 -> oRF_WE=1 that cycle and the entry appears in PREV.
- **Sysreg PSR write:** GR_DEST_SYSREG=1, DEST=PSR code, data 0x0000_0003 -> oWB_GR_DEST_SYSREG=1 with that pointer and data, then the same on PREV the following cycle.

Source files
------------

// File: rtl/execute_writeback_stage.sv
// Execute-to-writeback stage: current entry feeding the register-file write port
// plus a one-cycle history of the last retired write. Define EXECUTE_WB_FRCR_EN to add FRCR staging.
module execute_writeback_stage (
   input  logic        iCLOCK,
   input  logic        iRESET,
   input  logic        iFLUSH,
   input  logic        iEXE_VALID,
   output logic        oEXE_LOCK,
   input  logic        iEXE_GR_VALID,
   input  logic [31:0] iEXE_GR_DATA,
   input  logic [4:0]  iEXE_GR_DEST,
   input  logic        iEXE_GR_DEST_SYSREG,
   input  logic        iEXE_SPR_VALID,
   input  logic [31:0] iEXE_SPR_DATA,
`ifdef EXECUTE_WB_FRCR_EN
   input  logic        iEXE_FRCR_VALID,
   input  logic [63:0] iEXE_FRCR_DATA,
   output logic        oWB_FRCR_VALID,
   output logic [63:0] oWB_FRCR_DATA,
   output logic        oPREV_WB_FRCR_VALID,
   output logic [63:0] oPREV_WB_FRCR_DATA,
`endif
   input  logic        iRF_BUSY,
   output logic        oRF_WE,
   output logic        oWB_GR_VALID,
   output logic [31:0] oWB_GR_DATA,
   output logic [4:0]  oWB_GR_DEST,
   output logic        oWB_GR_DEST_SYSREG,
   output logic        oWB_SPR_VALID,
   output logic [31:0] oWB_SPR_DATA,
   output logic        oPREV_WB_GR_VALID,
   output logic [31:0] oPREV_WB_GR_DATA,
   output logic [4:0]  oPREV_WB_GR_DEST,
   output logic        oPREV_WB_GR_DEST_SYSREG,
   output logic        oPREV_WB_SPR_VALID,
   output logic [31:0] oPREV_WB_SPR_DATA
);

   logic        cur_v_q, cur_v_d;
   logic        wb_gr_valid_q, wb_gr_valid_d;
   logic [31:0] wb_gr_data_q, wb_gr_data_d;
   logic [4:0]  wb_gr_dest_q, wb_gr_dest_d;
   logic        wb_gr_sys_q, wb_gr_sys_d;
   logic        wb_spr_valid_q, wb_spr_valid_d;
   logic [31:0] wb_spr_data_q, wb_spr_data_d;
   logic        prev_gr_valid_q, prev_gr_valid_d;
   logic [31:0] prev_gr_data_q, prev_gr_data_d;
   logic [4:0]  prev_gr_dest_q, prev_gr_dest_d;
   logic        prev_gr_sys_q, prev_gr_sys_d;
   logic        prev_spr_valid_q, prev_spr_valid_d;
   logic [31:0] prev_spr_data_q, prev_spr_data_d;
`ifdef EXECUTE_WB_FRCR_EN
   logic        wb_frcr_valid_q, wb_frcr_valid_d;
   logic [63:0] wb_frcr_data_q, wb_frcr_data_d;
   logic        prev_frcr_valid_q, prev_frcr_valid_d;
   logic [63:0] prev_frcr_data_q, prev_frcr_data_d;
`endif

   logic retire;
   logic lock;
   logic accept;

   assign retire = cur_v_q && !iRF_BUSY;
   assign lock   = cur_v_q && iRF_BUSY;
   assign accept = iEXE_VALID && !lock && !iFLUSH;

   always_comb begin
      cur_v_d          = cur_v_q;
      wb_gr_valid_d    = wb_gr_valid_q;
      wb_gr_data_d     = wb_gr_data_q;
      wb_gr_dest_d     = wb_gr_dest_q;
      wb_gr_sys_d      = wb_gr_sys_q;
      wb_spr_valid_d   = wb_spr_valid_q;
      wb_spr_data_d    = wb_spr_data_q;
      prev_gr_valid_d  = 1'b0;
      prev_gr_data_d   = prev_gr_data_q;
      prev_gr_dest_d   = prev_gr_dest_q;
      prev_gr_sys_d    = prev_gr_sys_q;
      prev_spr_valid_d = 1'b0;
      prev_spr_data_d  = prev_spr_data_q;
`ifdef EXECUTE_WB_FRCR_EN
      wb_frcr_valid_d   = wb_frcr_valid_q;
      wb_frcr_data_d    = wb_frcr_data_q;
      prev_frcr_valid_d = 1'b0;
      prev_frcr_data_d  = prev_frcr_data_q;
`endif

      // Flush only drops an entry that is not retiring; a retiring one is
      // already committed and is emptied from the current stage either way.
      if (accept) begin
         cur_v_d        = 1'b1;
         wb_gr_valid_d  = iEXE_GR_VALID;
         wb_gr_data_d   = iEXE_GR_DATA;
         wb_gr_dest_d   = iEXE_GR_DEST;
         wb_gr_sys_d    = iEXE_GR_DEST_SYSREG;
         wb_spr_valid_d = iEXE_SPR_VALID;
         wb_spr_data_d  = iEXE_SPR_DATA;
`ifdef EXECUTE_WB_FRCR_EN
         wb_frcr_valid_d = iEXE_FRCR_VALID;
         wb_frcr_data_d  = iEXE_FRCR_DATA;
`endif
      end else if (retire || iFLUSH) begin
         cur_v_d        = 1'b0;
         wb_gr_valid_d  = 1'b0;
         wb_spr_valid_d = 1'b0;
`ifdef EXECUTE_WB_FRCR_EN
         wb_frcr_valid_d = 1'b0;
`endif
      end

      if (retire) begin
         prev_gr_valid_d  = wb_gr_valid_q;
         prev_gr_data_d   = wb_gr_data_q;
         prev_gr_dest_d   = wb_gr_dest_q;
         prev_gr_sys_d    = wb_gr_sys_q;
         prev_spr_valid_d = wb_spr_valid_q;
         prev_spr_data_d  = wb_spr_data_q;
`ifdef EXECUTE_WB_FRCR_EN
         prev_frcr_valid_d = wb_frcr_valid_q;
         prev_frcr_data_d  = wb_frcr_data_q;
`endif
      end
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         cur_v_q          <= 1'b0;
         wb_gr_valid_q    <= 1'b0;
         wb_gr_data_q     <= 32'd0;
         wb_gr_dest_q     <= 5'd0;
         wb_gr_sys_q      <= 1'b0;
         wb_spr_valid_q   <= 1'b0;
         wb_spr_data_q    <= 32'd0;
         prev_gr_valid_q  <= 1'b0;
         prev_gr_data_q   <= 32'd0;
         prev_gr_dest_q   <= 5'd0;
         prev_gr_sys_q    <= 1'b0;
         prev_spr_valid_q <= 1'b0;
         prev_spr_data_q  <= 32'd0;
`ifdef EXECUTE_WB_FRCR_EN
         wb_frcr_valid_q   <= 1'b0;
         wb_frcr_data_q    <= 64'd0;
         prev_frcr_valid_q <= 1'b0;
         prev_frcr_data_q  <= 64'd0;
`endif
      end else begin
         cur_v_q          <= cur_v_d;
         wb_gr_valid_q    <= wb_gr_valid_d;
         wb_gr_data_q     <= wb_gr_data_d;
         wb_gr_dest_q     <= wb_gr_dest_d;
         wb_gr_sys_q      <= wb_gr_sys_d;
         wb_spr_valid_q   <= wb_spr_valid_d;
         wb_spr_data_q    <= wb_spr_data_d;
         prev_gr_valid_q  <= prev_gr_valid_d;
         prev_gr_data_q   <= prev_gr_data_d;
         prev_gr_dest_q   <= prev_gr_dest_d;
         prev_gr_sys_q    <= prev_gr_sys_d;
         prev_spr_valid_q <= prev_spr_valid_d;
         prev_spr_data_q  <= prev_spr_data_d;
`ifdef EXECUTE_WB_FRCR_EN
         wb_frcr_valid_q   <= wb_frcr_valid_d;
         wb_frcr_data_q    <= wb_frcr_data_d;
         prev_frcr_valid_q <= prev_frcr_valid_d;
         prev_frcr_data_q  <= prev_frcr_data_d;
`endif
      end
   end

   assign oEXE_LOCK               = lock;
   assign oRF_WE                  = retire;
   assign oWB_GR_VALID            = wb_gr_valid_q;
   assign oWB_GR_DATA             = wb_gr_data_q;
   assign oWB_GR_DEST             = wb_gr_dest_q;
   assign oWB_GR_DEST_SYSREG      = wb_gr_sys_q;
   assign oWB_SPR_VALID           = wb_spr_valid_q;
   assign oWB_SPR_DATA            = wb_spr_data_q;
   assign oPREV_WB_GR_VALID       = prev_gr_valid_q;
   assign oPREV_WB_GR_DATA        = prev_gr_data_q;
   assign oPREV_WB_GR_DEST        = prev_gr_dest_q;
   assign oPREV_WB_GR_DEST_SYSREG = prev_gr_sys_q;
   assign oPREV_WB_SPR_VALID      = prev_spr_valid_q;
   assign oPREV_WB_SPR_DATA       = prev_spr_data_q;
`ifdef EXECUTE_WB_FRCR_EN
   assign oWB_FRCR_VALID          = wb_frcr_valid_q;
   assign oWB_FRCR_DATA           = wb_frcr_data_q;
   assign oPREV_WB_FRCR_VALID     = prev_frcr_valid_q;
   assign oPREV_WB_FRCR_DATA      = prev_frcr_data_q;
`endif

endmodule

// File: tb/tb_execute_writeback_stage.sv
// Directed, table-driven bench for execute_writeback_stage (default build, FRCR absent).
module tb_execute_writeback_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        exe_valid = 1'b0;
   logic        exe_lock;
   logic        gr_valid = 1'b0;
   logic [31:0] gr_data = '0;
   logic [4:0]  gr_dest = '0;
   logic        gr_sys = 1'b0;
   logic        spr_valid = 1'b0;
   logic [31:0] spr_data = '0;
   logic        rf_busy = 1'b0;
   logic        rf_we;
   logic        wb_gv, wb_sys, wb_sv;
   logic [31:0] wb_gd, wb_sd;
   logic [4:0]  wb_dest;
   logic        pv_gv, pv_sys, pv_sv;
   logic [31:0] pv_gd, pv_sd;
   logic [4:0]  pv_dest;

   int checks = 0;
   int passed = 0;

   localparam logic [4:0] PSR = 5'd2;

   always #5 clk = ~clk;

   execute_writeback_stage dut (
      .iCLOCK(clk), .iRESET(rst), .iFLUSH(flush),
      .iEXE_VALID(exe_valid), .oEXE_LOCK(exe_lock),
      .iEXE_GR_VALID(gr_valid), .iEXE_GR_DATA(gr_data), .iEXE_GR_DEST(gr_dest),
      .iEXE_GR_DEST_SYSREG(gr_sys), .iEXE_SPR_VALID(spr_valid), .iEXE_SPR_DATA(spr_data),
      .iRF_BUSY(rf_busy), .oRF_WE(rf_we),
      .oWB_GR_VALID(wb_gv), .oWB_GR_DATA(wb_gd), .oWB_GR_DEST(wb_dest),
      .oWB_GR_DEST_SYSREG(wb_sys), .oWB_SPR_VALID(wb_sv), .oWB_SPR_DATA(wb_sd),
      .oPREV_WB_GR_VALID(pv_gv), .oPREV_WB_GR_DATA(pv_gd), .oPREV_WB_GR_DEST(pv_dest),
      .oPREV_WB_GR_DEST_SYSREG(pv_sys), .oPREV_WB_SPR_VALID(pv_sv), .oPREV_WB_SPR_DATA(pv_sd)
   );

   typedef struct {
      logic        v, grv;
      logic [31:0] gd;
      logic [4:0]  dest;
      logic        sys, sprv;
      logic [31:0] sprd;
      logic        busy, fl;
      logic        e_lock, e_we;
      logic        e_wgv;
      logic [31:0] e_wgd;
      logic [4:0]  e_wdest;
      logic        e_wsys, e_wsv;
      logic [31:0] e_wsd;
      logic        e_pgv;
      logic [31:0] e_pgd;
      logic [4:0]  e_pdest;
      logic        e_psys, e_psv;
      logic [31:0] e_psd;
   } vec_t;

   vec_t vecs [24];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_lock"}, exe_lock, 0);
      check({tag, "_we"}, rf_we, 0);
      check({tag, "_wb"}, {wb_gv, wb_gd, wb_dest, wb_sys, wb_sv, wb_sd}, 0);
      check({tag, "_prev"}, {pv_gv, pv_gd, pv_dest, pv_sys, pv_sv, pv_sd}, 0);
   endtask

   task automatic drive(input logic v, input logic grv, input logic [31:0] gd, input logic [4:0] dest,
                        input logic sys, input logic sprv, input logic [31:0] sprd,
                        input logic busy, input logic fl);
      exe_valid = v; gr_valid = grv; gr_data = gd; gr_dest = dest; gr_sys = sys;
      spr_valid = sprv; spr_data = sprd; rf_busy = busy; flush = fl;
   endtask

   initial begin
      //          v grv data          dest  sys sprv sprd        busy fl | lock we | wgv wgd          wdest wsys wsv wsd        | pgv pgd          pdest psys psv psd
      // single write
      vecs[0]  = '{1,1,32'h12345678,5'd5, 0,0,32'h0,        0,0, 0,0, 1,32'h12345678,5'd5, 0,0,32'h0,        0,32'h0,       5'd0, 0,0,32'h0};
      vecs[1]  = '{0,0,32'h0,       5'd0, 0,0,32'h0,        0,0, 0,1, 0,32'h12345678,5'd5, 0,0,32'h0,        1,32'h12345678,5'd5, 0,0,32'h0};
      vecs[2]  = '{0,0,32'h0,       5'd0, 0,0,32'h0,        0,0, 0,0, 0,32'h12345678,5'd5, 0,0,32'h0,        0,32'h12345678,5'd5, 0,0,32'h0};
      // stall: three busy cycles while execute keeps offering B
      vecs[3]  = '{1,1,32'hAAAA0001,5'd7, 0,0,32'h0,        0,0, 0,0, 1,32'hAAAA0001,5'd7, 0,0,32'h0,        0,32'h12345678,5'd5, 0,0,32'h0};
      vecs[4]  = '{1,1,32'hBBBB0002,5'd8, 0,0,32'h0,        1,0, 1,0, 1,32'hAAAA0001,5'd7, 0,0,32'h0,        0,32'h12345678,5'd5, 0,0,32'h0};
      vecs[5]  = '{1,1,32'hBBBB0002,5'd8, 0,0,32'h0,        1,0, 1,0, 1,32'hAAAA0001,5'd7, 0,0,32'h0,        0,32'h12345678,5'd5, 0,0,32'h0};
      vecs[6]  = '{1,1,32'hBBBB0002,5'd8, 0,0,32'h0,        1,0, 1,0, 1,32'hAAAA0001,5'd7, 0,0,32'h0,        0,32'h12345678,5'd5, 0,0,32'h0};
      vecs[7]  = '{1,1,32'hBBBB0002,5'd8, 0,0,32'h0,        0,0, 0,1, 1,32'hBBBB0002,5'd8, 0,0,32'h0,        1,32'hAAAA0001,5'd7, 0,0,32'h0};
      // streaming DEST 1..4, SPR on the second
      vecs[8]  = '{1,1,32'h11,      5'd1, 0,0,32'h0,        0,0, 0,1, 1,32'h11,      5'd1, 0,0,32'h0,        1,32'hBBBB0002,5'd8, 0,0,32'h0};
      vecs[9]  = '{1,1,32'h22,      5'd2, 0,1,32'h0000FF00, 0,0, 0,1, 1,32'h22,      5'd2, 0,1,32'h0000FF00, 1,32'h11,      5'd1, 0,0,32'h0};
      vecs[10] = '{1,1,32'h33,      5'd3, 0,0,32'h0,        0,0, 0,1, 1,32'h33,      5'd3, 0,0,32'h0,        1,32'h22,      5'd2, 0,1,32'h0000FF00};
      vecs[11] = '{1,1,32'h44,      5'd4, 0,0,32'h0,        0,0, 0,1, 1,32'h44,      5'd4, 0,0,32'h0,        1,32'h33,      5'd3, 0,0,32'h0};
      vecs[12] = '{0,0,32'h0,       5'd0, 0,0,32'h0,        0,0, 0,1, 0,32'h44,      5'd4, 0,0,32'h0,        1,32'h44,      5'd4, 0,0,32'h0};
      vecs[13] = '{0,0,32'h0,       5'd0, 0,0,32'h0,        0,0, 0,0, 0,32'h44,      5'd4, 0,0,32'h0,        0,32'h44,      5'd4, 0,0,32'h0};
      // flush while held: entry dropped, never written
      vecs[14] = '{1,1,32'hCCCC0003,5'd9, 0,0,32'h0,        0,0, 0,0, 1,32'hCCCC0003,5'd9, 0,0,32'h0,        0,32'h44,      5'd4, 0,0,32'h0};
      vecs[15] = '{0,0,32'h0,       5'd0, 0,0,32'h0,        1,1, 1,0, 0,32'hCCCC0003,5'd9, 0,0,32'h0,        0,32'h44,      5'd4, 0,0,32'h0};
      vecs[16] = '{0,0,32'h0,       5'd0, 0,0,32'h0,        0,0, 0,0, 0,32'hCCCC0003,5'd9, 0,0,32'h0,        0,32'h44,      5'd4, 0,0,32'h0};
      // flush while retiring: write commits, new result rejected
      vecs[17] = '{1,1,32'hDDDD0004,5'd10,0,0,32'h0,        0,0, 0,0, 1,32'hDDDD0004,5'd10,0,0,32'h0,        0,32'h44,      5'd4, 0,0,32'h0};
      vecs[18] = '{1,1,32'hEEEE0005,5'd11,0,0,32'h0,        0,1, 0,1, 0,32'hDDDD0004,5'd10,0,0,32'h0,        1,32'hDDDD0004,5'd10,0,0,32'h0};
      vecs[19] = '{0,0,32'h0,       5'd0, 0,0,32'h0,        0,0, 0,0, 0,32'hDDDD0004,5'd10,0,0,32'h0,        0,32'hDDDD0004,5'd10,0,0,32'h0};
      // sysreg PSR write
      vecs[20] = '{1,1,32'h3,       PSR,  1,0,32'h0,        0,0, 0,0, 1,32'h3,       PSR,  1,0,32'h0,        0,32'hDDDD0004,5'd10,0,0,32'h0};
      vecs[21] = '{0,0,32'h0,       5'd0, 0,0,32'h0,        0,0, 0,1, 0,32'h3,       PSR,  1,0,32'h0,        1,32'h3,       PSR,  1,0,32'h0};
      // accept with no write still occupies the stage and retires
      vecs[22] = '{1,0,32'h0,       5'd0, 0,0,32'h0,        0,0, 0,0, 0,32'h0,       5'd0, 0,0,32'h0,        0,32'h3,       PSR,  1,0,32'h0};
      vecs[23] = '{0,0,32'h0,       5'd0, 0,0,32'h0,        0,0, 0,1, 0,32'h0,       5'd0, 0,0,32'h0,        0,32'h0,       5'd0, 0,0,32'h0};

      #2 rst = 1'b1;
      #2 check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 24; i++) begin
         drive(vecs[i].v, vecs[i].grv, vecs[i].gd, vecs[i].dest, vecs[i].sys,
               vecs[i].sprv, vecs[i].sprd, vecs[i].busy, vecs[i].fl);
         #1;
         check($sformatf("v%0d_lock", i), exe_lock, vecs[i].e_lock);
         check($sformatf("v%0d_we", i), rf_we, vecs[i].e_we);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_wb", i), {wb_gv, wb_gd, wb_dest, wb_sys, wb_sv, wb_sd},
               {vecs[i].e_wgv, vecs[i].e_wgd, vecs[i].e_wdest, vecs[i].e_wsys, vecs[i].e_wsv, vecs[i].e_wsd});
         check($sformatf("v%0d_prev", i), {pv_gv, pv_gd, pv_dest, pv_sys, pv_sv, pv_sd},
               {vecs[i].e_pgv, vecs[i].e_pgd, vecs[i].e_pdest, vecs[i].e_psys, vecs[i].e_psv, vecs[i].e_psd});
      end

      // asynchronous reset with a held entry and the write port busy
      drive(1, 1, 32'hFFFF0006, 5'd12, 0, 1, 32'h00AB0000, 0, 0);
      @(posedge clk);
      #1 drive(1, 1, 32'h12121212, 5'd13, 0, 0, 32'h0, 1, 0);
      #1 check("mid_lock", exe_lock, 1);
      check("mid_wb", {wb_gv, wb_gd, wb_dest, wb_sv, wb_sd}, {1'b1, 32'hFFFF0006, 5'd12, 1'b1, 32'h00AB0000});
      #1 rst = 1'b1;
      #1 check_all_zero("async_rst");
      #1 rst = 1'b0;
      drive(0, 0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 0);
      @(posedge clk);
      #1 check_all_zero("post_rst");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
